// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns symbolic MIPS instruction requests into 32-bit
// instruction words and streams them into instruction memory at sequential
// byte addresses starting from BASE_ADDR.
//
// Optional build macro ENC_ILLEGAL_TRAP_EN:
//   defined   - illegal requests are handshaken, flag err, and are dropped
//   undefined - illegal requests flag err and are written as a NOP (32'h0)
module mips_instr_encoder #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CW        = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    cls,
   input  logic [2:0]    alusel,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   output logic          wr_valid,
   input  logic          wr_ready,
   output logic [31:0]   waddr,
   output logic [31:0]   wdata,
   output logic [CW-1:0] count,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [31:0] DepthU = DEPTH;

   state_t        state_q, state_d;
   logic [31:0]   waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   logic [31:0]   encWord;
   logic          isIllegal;
   logic [5:0]    funct;
   logic [31:0]   countPlusOne;
   logic          inReady;
   logic          accept;
   logic          loadWord;
   logic          writeFire;

   // Encode the request into a MIPS word and flag classes/ALU codes we cannot encode.
   always_comb begin
      encWord   = 32'h0000_0000;
      isIllegal = 1'b0;
      funct     = 6'b000000;
      case (alusel)
         3'b010:  funct = 6'b100000;
         3'b110:  funct = 6'b100010;
         3'b000:  funct = 6'b100100;
         3'b001:  funct = 6'b100101;
         3'b111:  funct = 6'b101010;
         default: funct = 6'b000000;
      endcase
      case (cls)
         3'd0: begin
            encWord   = {6'b000000, rs, rt, rd, 5'b00000, funct};
            isIllegal = (funct == 6'b000000);
         end
         3'd1:    encWord = {6'b100011, rs, rt, imm};
         3'd2:    encWord = {6'b101011, rs, rt, imm};
         3'd3:    encWord = {6'b000100, rs, rt, imm};
         3'd4:    encWord = {6'b001000, rs, rt, imm};
         3'd5:    encWord = {6'b000010, target};
         default: isIllegal = 1'b1;
      endcase
      if (isIllegal) begin
         encWord = 32'h0000_0000;
      end
   end

   // Handshake qualification: a new request may overlap the final write of a
   // pending word only if that write does not fill the memory.
   always_comb begin
      countPlusOne = {{(32-CW){1'b0}}, count_q} + 32'd1;
      inReady      = (state_q == IDLE) ||
                     ((state_q == HOLD) && wr_ready && (countPlusOne < DepthU));
      accept       = in_valid && inReady;
      writeFire    = (state_q == HOLD) && wr_ready;
`ifdef ENC_ILLEGAL_TRAP_EN
      loadWord     = accept && !isIllegal;
`else
      loadWord     = accept;
`endif
   end

   // Next-state logic: load words, retire writes, and restart on clr.
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      err_d   = err_q;
      if (accept && isIllegal) begin
         err_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (loadWord) begin
               wdata_d = encWord;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (writeFire) begin
               waddr_d = waddr_q + 32'd4;
               count_d = countPlusOne[CW-1:0];
               if (countPlusOne == DepthU) begin
                  state_d = FULL;
               end else if (loadWord) begin
                  wdata_d = encWord;
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FULL:    state_d = FULL;
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         waddr_d = BASE_ADDR;
         wdata_d = wdata_q;
         count_d = '0;
         err_d   = err_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         waddr_q <= BASE_ADDR;
         wdata_q <= 32'h0000_0000;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = inReady;
   assign wr_valid = (state_q == HOLD);
   assign done     = (state_q == FULL);
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign count    = count_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed and random requests; accepted requests push
// their expected word into a scoreboard queue that a negedge monitor drains.
module tb_mips_instr_encoder;

   localparam int          DEPTH = 5;
   localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
   localparam int          CW    = 3;

   logic          clk;
   logic          reset;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    cls;
   logic [2:0]    alusel;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [15:0]   imm;
   logic [25:0]   target;
   logic          wr_valid;
   logic          wr_ready;
   logic [31:0]   waddr;
   logic [31:0]   wdata;
   logic [CW-1:0] count;
   logic          done;
   logic          err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] expQ[$];
   int          modelWrites = 0;
   bit          modelErr    = 1'b0;
   bit          modelValid  = 1'b0;
   bit          wdataZero   = 1'b0;

   mips_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CW(CW)) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .cls(cls), .alusel(alusel), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .waddr(waddr), .wdata(wdata), .count(count),
      .done(done), .err(err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference encoder built from the opcode/funct tables as plain numbers.
   function automatic logic [31:0] refEncode(input logic [2:0] c, input logic [2:0] al,
                                             input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [15:0] im,
                                             input logic [25:0] tg, output bit illegal);
      logic [31:0] word;
      int          fn;
      illegal = 1'b0;
      word    = 32'h0;
      case (al)
         3'b010:  fn = 32;
         3'b110:  fn = 34;
         3'b000:  fn = 36;
         3'b001:  fn = 37;
         3'b111:  fn = 42;
         default: fn = -1;
      endcase
      case (c)
         3'd0: begin
            if (fn < 0) illegal = 1'b1;
            else word = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(fn);
         end
         3'd1:    word = (32'd35 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
         3'd2:    word = (32'd43 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
         3'd3:    word = (32'd4  << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
         3'd4:    word = (32'd8  << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
         3'd5:    word = (32'd2  << 26) | 32'(tg);
         default: illegal = 1'b1;
      endcase
      return illegal ? 32'h0 : word;
   endfunction

   // Monitor: compare outputs with the model, then advance the model by what
   // the next rising edge will do.
   always @(negedge clk) begin
      bit          pending;
      bit          expReady;
      bit          illegal;
      logic [31:0] w;
      pending  = (expQ.size() > 0);
      expReady = (modelWrites < DEPTH) &&
                 (!pending || (wr_ready && (modelWrites + 1 < DEPTH)));
      if (modelValid) begin
         checkOutput("in_ready", 32'(in_ready), 32'(expReady));
         checkOutput("wr_valid", 32'(wr_valid), 32'(pending));
         checkOutput("waddr", waddr, BASE + 32'(4 * modelWrites));
         checkOutput("count", 32'(count), 32'(modelWrites));
         checkOutput("done", 32'(done), 32'(modelWrites == DEPTH));
         checkOutput("err", 32'(err), 32'(modelErr));
         if (pending) checkOutput("wdata", wdata, expQ[0]);
         else if (wdataZero) checkOutput("wdata_reset", wdata, 32'h0);
      end
      if (reset) begin
         expQ.delete();
         modelWrites = 0;
         modelErr    = 1'b0;
         wdataZero   = 1'b1;
         modelValid  = 1'b1;
      end else if (modelValid) begin
         if (clr) begin
            expQ.delete();
            modelWrites = 0;
         end else begin
            if (pending && wr_ready) begin
               void'(expQ.pop_front());
               modelWrites++;
            end
            if (in_valid && expReady) begin
               w = refEncode(cls, alusel, rs, rt, rd, imm, target, illegal);
               if (illegal) modelErr = 1'b1;
`ifdef ENC_ILLEGAL_TRAP_EN
               if (!illegal) begin
                  expQ.push_back(w);
                  wdataZero = 1'b0;
               end
`else
               expQ.push_back(w);
               wdataZero = 1'b0;
`endif
            end
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [2:0] al,
                                input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                input logic [15:0] im, input logic [25:0] tg,
                                input logic wr, input logic cl);
      in_valid = v;  cls = c;  alusel = al;  rs = s;  rt = t;  rd = d;
      imm = im;  target = tg;  wr_ready = wr;  clr = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input logic wr);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, wr, 1'b0);
   endtask

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      reset = 1'b1;
      in_valid = 1'b0; cls = 3'd0; alusel = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
      imm = 16'h0; target = 26'h0; wr_ready = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      idleCycles(1, 1'b1);

      applyStimulus(1'b1, 3'd0, 3'b010, 5'd17, 5'd18, 5'd16, 16'h0, 26'h0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);

      applyStimulus(1'b1, 3'd1, 3'd0, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd4, 3'd0, 5'd0,  5'd2, 5'd0, 16'h0005, 26'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd3, 3'd0, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd5, 3'd0, 5'd0,  5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0, 1'b1, 1'b1);
      idleCycles(1, 1'b1);

      applyStimulus(1'b1, 3'd0, 3'b110, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 3'd0, 3'b111, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b0, 1'b0);
      idleCycles(2, 1'b1);

      applyStimulus(1'b1, 3'd6, 3'd0, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);
      applyStimulus(1'b1, 3'd0, 3'b011, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);
      applyStimulus(1'b1, 3'd4, 3'd0, 5'd9, 5'd9, 5'd0, 16'h8000, 26'h0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);

      applyStimulus(1'b1, 3'd0, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1);
      idleCycles(1, 1'b1);
      applyStimulus(1'b1, 3'd0, 3'b001, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd1, 3'd0, 5'd7, 5'd8, 5'd0, 16'h00FF, 26'h0, 1'b1, 1'b1);
      idleCycles(2, 1'b1);

      for (int i = 0; i < 800; i++) begin
         logic [2:0] c;
         logic [2:0] al;
         c  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         al = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 9) < 7, c, al, 5'($urandom), 5'($urandom),
                       5'($urandom), 16'($urandom), 26'($urandom),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
      end
      reset = 1'b0;
      idleCycles(4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the main/ALU decode path. Takes symbolic instruction requests (class, ALU op, register fields, immediate or jump target) and encodes 32-bit MIPS words.
- Streams encoded words into instruction memory through a write port, with sequential addressing.
- Used by the bench/boot loader to fill imem before the single-cycle core runs.
- Accepts at most one request per cycle; skid-free pass-through pipeline.

Parameters:
- DEPTH, 64, number of words that fit in imem (≥1)
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- CW, 7, width of count output; must satisfy 2^CW > DEPTH

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- clr  in  1  synchronous restart: drop pending word, address back to BASE_ADDR
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- cls  in  3  0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J; 6,7 illegal
- alusel  in  3  RTYPE only, ALU control code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- rs  in  5  source register
- rt  in  5  second source / load destination
- rd  in  5  RTYPE destination
- imm  in  16  immediate / branch offset
- target  in  26  J target field
- wr_valid  out  1  imem write request
- wr_ready  in  1  imem accepts the write when wr_valid & wr_ready
- waddr  out  32  byte address of the write
- wdata  out  32  encoded instruction
- count  out  CW  words written since reset/clr
- done  out  1  DEPTH words written
- err  out  1  sticky illegal-request flag

Behaviour:
- Opcode map: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Funct map (RTYPE): 010→100000, 110→100010, 000→100100, 001→100101, 111→101010.
- Encoding rules:
  - RTYPE: {op, rs, rt, rd, 5'b0, funct}
  - LW/SW/BEQ/ADDI: {op, rs, rt, imm}
  - J: {op, target}
  - Unused input fields are ignored.
- Illegal request: cls 6 or 7, or RTYPE with any other alusel.
- FSM states: IDLE (no pending word), HOLD (wr_valid=1), FULL (done=1).
- IDLE:
  - Handshake → HOLD; wdata is registered from the request.
  - Latency: request accepted in cycle N appears on wr_valid/wdata in cycle N+1.
- HOLD:
  - On wr_valid & wr_ready: waddr += 4, count += 1.
  - If count reaches DEPTH → FULL.
  - Else if a new request is accepted in the same cycle, stay in HOLD with the new word; otherwise → IDLE.
- in_ready = (state==IDLE) | (state==HOLD & wr_ready & count+1<DEPTH). Zero in FULL.
- While wr_ready=0 in HOLD, wdata and waddr stay stable.
- FULL: in_ready=0, wr_valid=0, done=1. Leaves only on reset or clr.
- clr: next state IDLE, waddr=BASE_ADDR, count=0, done=0, wr_valid=0. Any pending or simultaneously offered word is discarded. err is not cleared by clr.
- reset: applies everything clr does, and also err=0 and wdata=0.
- Reset values: in_ready=1 (state IDLE after reset), wr_valid=0, waddr=BASE_ADDR, wdata=0, count=0, done=0, err=0.
- waddr wraps modulo 2^32; no other arithmetic overflow is possible while count ≤ DEPTH.

Optional Feature:
- Macro ENC_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal request is handshaken (in_ready behaves normally), sets err, and is dropped.
  - No write occurs; count and waddr are unchanged.
  - State stays IDLE, or HOLD if a previous word is still pending.
- Undefined:
  - Illegal request sets err and is encoded as NOP 32'h0000_0000.
  - The NOP is written like any other word.

Test Plan:
- Reset, then RTYPE alusel=010 rs=17 rt=18 rd=16, wr_ready=1 → next cycle wr_valid=1, wdata=0x02328020, waddr=0x0; then count=1.
- Back-to-back LW rs=29 rt=8 imm=4; ADDI rs=0 rt=2 imm=5; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10, wr_ready=1 → wdata sequence 0x8FA80004, 0x20020005, 0x1022FFFF, 0x08000010 at waddr 0x0, 0x4, 0x8, 0xC; in_ready stays 1.
- Hold wr_ready=0 for 3 cycles with a word pending → wdata/waddr stable, in_ready=0; release → one write, count+1.
- DEPTH=4, send 5 requests → done=1 after the 4th write, in_ready=0, 5th request never accepted; clr → count=0, waddr=BASE_ADDR, in_ready=1.
- cls=6 → err=1. Without the macro: write of 0x00000000. With ENC_ILLEGAL_TRAP_EN: no write and count unchanged. RTYPE alusel=011 behaves the same.
- clr asserted in the same cycle as a handshake while in HOLD → no write in the following cycle, wr_valid=0, count=0.
